// File: rtl/seed_conditioner.sv
// Seed conditioner for the xorshift32 digit generator: synchronises and debounces the
// raw seed switches, then emits a whitened, never-zero 32-bit seed with a one-cycle load strobe.
module seed_conditioner #(
    parameter int          SEED_W          = 6,
    parameter int          DEBOUNCE_CYCLES = 16,
    parameter logic [31:0] SEED_CONST      = 32'h9E3779B9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SEED_W-1:0] seed_raw,
    output logic              seed_load,
    output logic [31:0]       seed_word,
    output logic              busy
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        LOAD
    } state_t;

    state_t            state;
    logic [SEED_W-1:0] sync1;
    logic [SEED_W-1:0] sync2;
    logic [SEED_W-1:0] candidate;
    logic [SEED_W-1:0] committed;
    logic              committed_valid;
    logic [CW-1:0]     counter;

    // Repeat the switch value across 32 bits, whiten it, and never hand out zero:
    // an all-zero state locks xorshift permanently.
    function automatic logic [31:0] expand(input logic [SEED_W-1:0] s);
        logic [31:0] w;
        for (int i = 0; i < 32; i++) begin
            w[i] = s[i % SEED_W];
        end
        w = w ^ SEED_CONST;
        if (w == 32'h0) begin
            w = 32'h0000_0001;
        end
        return w;
    endfunction

    // NOTE: every flop uses non-blocking assignments so all of them sample pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= seed_raw;
            sync2 <= sync1;
        end
    end

    // Reset starts in SETTLE with no committed value, so a first strobe always follows reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= SETTLE;
            candidate       <= '0;
            committed       <= '0;
            committed_valid <= 1'b0;
            counter         <= '0;
            seed_load       <= 1'b0;
            seed_word       <= SEED_CONST;
            busy            <= 1'b1;
        end else begin
            seed_load <= 1'b0;
            case (state)
                IDLE: begin
                    if (sync2 != committed) begin
                        state     <= SETTLE;
                        candidate <= sync2;
                        counter   <= '0;
                        busy      <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (sync2 != candidate) begin
                        candidate <= sync2;
                        counter   <= '0;
                    end else if (counter == CNT_LAST) begin
                        if (!committed_valid || candidate != committed) begin
                            state     <= LOAD;
                            seed_load <= 1'b1;
                            seed_word <= expand(candidate);
                        end else begin
                            // Bounced back to the value already loaded: nothing to reseed.
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                LOAD: begin
                    committed       <= candidate;
                    committed_valid <= 1'b1;
                    state           <= IDLE;
                    busy            <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seed_conditioner.sv
// Bench for seed_conditioner: a 16-cycle instance with the default constant and a 2-cycle
// instance whose constant makes one switch value expand to zero before the guard.
module tb_seed_conditioner;

    localparam int          D  = 16;
    localparam int          D2 = 2;
    localparam logic [31:0] C  = 32'h9E3779B9;
    localparam logic [31:0] C2 = 32'h55555555;

    logic        clk = 1'b0;
    logic        rst, rst2;
    logic [5:0]  raw, raw2;
    logic        load, load2;
    logic [31:0] word, word2;
    logic        busy, busy2;

    int tests = 0;
    int fails = 0;
    int edge_n = 0;
    int t, r;
    int found;

    typedef struct {
        int          cyc;
        logic [31:0] word;
    } exp_t;

    typedef struct {
        logic [5:0]  raw;
        logic [31:0] word;
    } vec_t;

    exp_t q[$];
    exp_t q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    seed_conditioner #(.SEED_W(6), .DEBOUNCE_CYCLES(D), .SEED_CONST(C)) u_main (
        .clk       (clk),
        .rst       (rst),
        .seed_raw  (raw),
        .seed_load (load),
        .seed_word (word),
        .busy      (busy)
    );

    seed_conditioner #(.SEED_W(6), .DEBOUNCE_CYCLES(D2), .SEED_CONST(C2)) u_min (
        .clk       (clk),
        .rst       (rst2),
        .seed_raw  (raw2),
        .seed_load (load2),
        .seed_word (word2),
        .busy      (busy2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Expansion for the 2-cycle instance: {s[1:0],s,s,s,s,s} ^ C2, zero replaced by 1.
    function automatic logic [31:0] expand2(input logic [5:0] s);
        logic [31:0] w;
        w = {s[1:0], s, s, s, s, s} ^ C2;
        if (w == 32'h0) w = 32'h1;
        return w;
    endfunction

    // Scoreboard: every strobe must match the oldest expected {edge, word}.
    always @(negedge clk) begin
        exp_t e;
        if (load === 1'b1) begin
            if (q.size() == 0) begin
                check("main_unexpected_strobe", {31'b0, load}, 32'h0);
            end else begin
                e = q.pop_front();
                check("main_strobe_edge", edge_n, e.cyc);
                check("main_seed_word", word, e.word);
                check("main_busy_at_load", {31'b0, busy}, 32'h1);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (load2 === 1'b1) begin
            if (q2.size() == 0) begin
                check("min_unexpected_strobe", {31'b0, load2}, 32'h0);
            end else begin
                e = q2.pop_front();
                check("min_strobe_edge", edge_n, e.cyc);
                check("min_seed_word", word2, e.word);
                check("min_word_nonzero", {31'b0, (word2 != 32'h0)}, 32'h1);
            end
        end
    end

    task automatic drain(input string name);
        for (int i = 0; i < 300 && (q.size() != 0 || q2.size() != 0); i++) begin
            @(negedge clk);
        end
        check({name, "_main_pending"}, q.size(), 0);
        check({name, "_min_pending"}, q2.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, edge %0d", edge_n);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        vecs[0] = '{6'h2A, 32'h349DD313};
        vecs[1] = '{6'h15, 32'hCB622CEC};
        vecs[2] = '{6'h01, 32'hDF3369F8};
        vecs[3] = '{6'h3F, 32'h61C88646};

        // Reset for 3 cycles with switches at zero.
        rst  = 1'b1;
        rst2 = 1'b1;
        raw  = 6'h00;
        raw2 = 6'h00;
        @(negedge clk);
        check("rst_seed_load", {31'b0, load}, 32'h0);
        check("rst_seed_word", word, C);
        check("rst_busy", {31'b0, busy}, 32'h1);
        check("rst_min_seed_word", word2, C2);
        repeat (2) @(negedge clk);
        rst  = 1'b0;
        rst2 = 1'b0;
        r = edge_n;
        q.push_back('{r + D, C});
        q2.push_back('{r + D2, C2});
        repeat (D) @(negedge clk);
        check("t1_load_high", {31'b0, load}, 32'h1);
        @(negedge clk);
        check("t1_load_one_cycle", {31'b0, load}, 32'h0);
        check("t1_busy_fall", {31'b0, busy}, 32'h0);
        drain("t1");

        // Table of clean changes from IDLE; the last entry leaves 6'h3F committed.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            raw = vecs[k].raw;
            t = edge_n + 1;
            q.push_back('{t + 2 + D, vecs[k].word});
            repeat (D + 8) @(negedge clk);
            check("tbl_busy_idle", {31'b0, busy}, 32'h0);
        end
        drain("tbl");

        // Long idle: no further strobes, word held.
        repeat (200) @(negedge clk);
        check("idle_word_held", word, 32'h61C88646);
        check("idle_busy", {31'b0, busy}, 32'h0);

        // Short pulse to zero and back to the committed value.
        @(negedge clk);
        raw = 6'h00;
        repeat (4) @(negedge clk);
        raw = 6'h3F;
        check("pulse_busy_settling", {31'b0, busy}, 32'h1);
        repeat (D + 10) @(negedge clk);
        check("pulse_word_unchanged", word, 32'h61C88646);
        check("pulse_busy_idle", {31'b0, busy}, 32'h0);

        // Change the input during the LOAD cycle: both values must be loaded.
        @(negedge clk);
        raw = 6'h2A;
        t = edge_n + 1;
        q.push_back('{t + 2 + D, 32'h349DD313});
        found = 0;
        for (int i = 0; i < D + 10; i++) begin
            @(negedge clk);
            if (load === 1'b1) begin
                found = 1;
                break;
            end
        end
        check("lc_strobe_seen", found, 1);
        raw = 6'h01;
        t = edge_n + 1;
        q.push_back('{t + 2 + D, 32'hDF3369F8});
        drain("lc");

        // Toggle 01/02 every 5 cycles for 100 cycles, then hold 02.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            raw = i[0] ? 6'h02 : 6'h01;
            if (i == 19) begin
                t = edge_n + 1;
                q.push_back('{t + 2 + D, 32'h1C3F593B});
            end
            repeat (4) @(negedge clk);
        end
        drain("toggle");
        check("toggle_word", word, 32'h1C3F593B);

        // Reset while the counter sits at D-2: no strobe, reset outputs, fresh strobe after.
        @(negedge clk);
        raw = 6'h15;
        t = edge_n + 1;
        repeat (D + 1) @(negedge clk);
        check("mid_busy_settling", {31'b0, busy}, 32'h1);
        rst = 1'b1;
        #1;
        check("mid_rst_load", {31'b0, load}, 32'h0);
        check("mid_rst_word", word, C);
        check("mid_rst_busy", {31'b0, busy}, 32'h1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        r = edge_n;
        q.push_back('{r + 3 + D, 32'hCB622CEC});
        drain("mid_rst");

        // Minimum debounce: 5-edge latency and a non-zero word for every switch value.
        for (int v = 1; v <= 64; v++) begin
            @(negedge clk);
            raw2 = 6'(v);
            t = edge_n + 1;
            q2.push_back('{t + 4, expand2(6'(v))});
            repeat (7) @(negedge clk);
        end
        drain("min_sweep");
        check("min_zero_guard", expand2(6'h15), 32'h1);
        check("min_final_word", word2, C2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
